sisc_ifetch: RTL and testbench



---
 rtl/sisc_pkg.sv | 28 ++
 rtl/sisc_pc_next.sv | 41 ++++
 rtl/sisc_ifetch.sv | 134 +++++++++++++
 tb/tb_sisc_ifetch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// sisc_pkg: shared definitions for the SISC instruction fetch slice.
// Holds the fetch FSM state type, default fetch parameters and the
// instruction field positions used by downstream decode logic.
package sisc_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } ifetch_state_e;

  // Default fetch configuration.
  localparam int SISC_PC_W     = 16;
  localparam int SISC_RESET_PC = 0;
  localparam int SISC_TIMEOUT  = 15;

  // Instruction word field positions.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int MM_MSB     = 27;
  localparam int MM_LSB     = 24;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;

endpackage

// File: rtl/sisc_pc_next.sv
// sisc_pc_next: combinational branch redirect for the fetch stage.
// Computes the pc to use after an instruction retires.
//   pc        in   current pc (already points past the retiring instruction)
//   br_take   in   branch taken
//   br_abs    in   1 = absolute target, 0 = pc-relative offset
//   br_target in   16-bit immediate
//   pc_next   out  redirected pc, modulo 2^PC_W
module sisc_pc_next
  import sisc_pkg::*;
#(
  parameter int PC_W = SISC_PC_W
) (
  input  logic [PC_W-1:0]  pc,
  input  logic             br_take,
  input  logic             br_abs,
  input  logic [IMM_W-1:0] br_target,
  output logic [PC_W-1:0]  pc_next
);

  // Work at least as wide as the immediate so narrow and wide pcs both
  // take the right slice of a zero- or sign-extended target.
  localparam int EXT_W = (PC_W > IMM_W) ? PC_W : IMM_W;

  logic [EXT_W-1:0] tgt_zext;
  logic [EXT_W-1:0] tgt_sext;

  always_comb begin
    tgt_zext = EXT_W'(br_target);
    tgt_sext = EXT_W'($signed(br_target));
    pc_next  = pc;
    if (br_take) begin
      if (br_abs) begin
        pc_next = tgt_zext[PC_W-1:0];
      end else begin
        // Truncating addition gives the silent wrap.
        pc_next = pc + tgt_sext[PC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sisc_ifetch.sv
// sisc_ifetch: instruction fetch stage for the SISC processor.
// Owns the pc, issues one instruction memory read at a time, holds the
// returned word in ir until ctrl retires it, then applies any branch.
//   clk, rst_f            clock (rising edge), async active-low reset
//   fetch_en, stall       permit / block issue of a new request
//   retire                consume ir; br_take/br_abs/br_target sampled here
//   imem_req/imem_addr    read request and word address (== pc)
//   imem_rdata/imem_valid memory response
//   ir, ir_valid          held instruction word and its valid flag
//   pc                    address of next fetch
//   fetch_fault           sticky memory-timeout flag (cleared by reset only)
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter int          PC_W     = SISC_PC_W,
  parameter int unsigned RESET_PC = SISC_RESET_PC,
  parameter int          TIMEOUT  = SISC_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             fetch_en,
  input  logic             stall,
  input  logic             retire,
  input  logic             br_take,
  input  logic             br_abs,
  input  logic [IMM_W-1:0] br_target,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  output logic [31:0]      ir,
  output logic             ir_valid,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_fault
);

  // Counter only has to reach TIMEOUT-1: the TIMEOUT-th empty WAIT cycle
  // goes straight to FAULT.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  ifetch_state_e    state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, pc_redirect;
  logic [31:0]      ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic             req_q, req_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sisc_pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc        (pc_q),
    .br_take   (br_take),
    .br_abs    (br_abs),
    .br_target (br_target),
    .pc_next   (pc_redirect)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    req_d      = req_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_en && !stall) begin
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // stall is deliberately ignored: an issued request always completes.
        if (imem_valid) begin
          ir_d       = imem_rdata;
          ir_valid_d = 1'b1;
          req_d      = 1'b0;
          pc_d       = pc_q + PC_W'(1);
          state_d    = ST_HOLD;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        // Retire wins over fetch_en, leaving a one-cycle bubble in IDLE.
        if (retire) begin
          ir_valid_d = 1'b0;
          pc_d       = pc_redirect;
          state_d    = ST_IDLE;
        end
      end
      ST_FAULT: begin
        req_d      = 1'b0;
        ir_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= ST_IDLE;
      pc_q       <= PC_W'(RESET_PC);
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      req_q      <= req_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_sisc_ifetch.sv
// tb_sisc_ifetch: directed self-checking bench for sisc_ifetch.
// A behavioural model tracks what the fetch stage must present each cycle
// and is compared against the DUT on every falling edge; literal checks at
// key points pin the model to hand-computed values.
module tb_sisc_ifetch;

  localparam int PC_W     = 16;
  localparam int RESET_PC = 0;
  localparam int TIMEOUT  = 15;

  logic        clk        = 1'b0;
  logic        rst_f      = 1'b0;
  logic        fetch_en   = 1'b0;
  logic        stall      = 1'b0;
  logic        retire     = 1'b0;
  logic        br_take    = 1'b0;
  logic        br_abs     = 1'b0;
  logic [15:0] br_target  = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] ir;
  logic        ir_valid;
  logic [15:0] pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_pass   = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  sisc_ifetch #(.PC_W(PC_W), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .fetch_en    (fetch_en),
    .stall       (stall),
    .retire      (retire),
    .br_take     (br_take),
    .br_abs      (br_abs),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .pc          (pc),
    .fetch_fault (fetch_fault)
  );

  // Behavioural model: a request is either outstanding, an instruction is
  // held, the stage has faulted, or it is idle.
  logic [15:0] m_pc     = 16'(RESET_PC);
  logic [31:0] m_ir     = '0;
  logic        m_held   = 1'b0;
  logic        m_busy   = 1'b0;
  logic        m_fault  = 1'b0;
  int          m_waited = 0;

  // Branch destination from plain integer arithmetic modulo 2^16.
  function automatic logic [15:0] branchDest(input logic [15:0] pc_now,
                                             input logic abs,
                                             input logic [15:0] tgt);
    int off;
    int sum;
    if (abs) return tgt;
    off = (tgt >= 16'h8000) ? int'(tgt) - 65536 : int'(tgt);
    sum = (int'(pc_now) + off) % 65536;
    if (sum < 0) sum = sum + 65536;
    return 16'(sum);
  endfunction

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      m_pc     <= 16'(RESET_PC);
      m_ir     <= '0;
      m_held   <= 1'b0;
      m_busy   <= 1'b0;
      m_fault  <= 1'b0;
      m_waited <= 0;
    end else if (m_fault) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      m_waited <= m_waited + 1;
      if (imem_valid) begin
        m_ir   <= imem_rdata;
        m_held <= 1'b1;
        m_busy <= 1'b0;
        m_pc   <= m_pc + 16'd1;
      end else if (m_waited + 1 >= TIMEOUT) begin
        m_busy  <= 1'b0;
        m_fault <= 1'b1;
      end
    end else if (m_held) begin
      if (retire) begin
        m_held <= 1'b0;
        if (br_take) m_pc <= branchDest(m_pc, br_abs, br_target);
      end
    end else if (fetch_en && !stall) begin
      m_busy   <= 1'b1;
      m_waited <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_imem_req",    32'(imem_req),    32'(m_busy));
      checkOutput("cyc_imem_addr",   32'(imem_addr),   32'(m_pc));
      checkOutput("cyc_pc",          32'(pc),          32'(m_pc));
      checkOutput("cyc_ir",          ir,               m_ir);
      checkOutput("cyc_ir_valid",    32'(ir_valid),    32'(m_held));
      checkOutput("cyc_fetch_fault", 32'(fetch_fault), 32'(m_fault));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive every input for the next rising edge, then advance past it.
  task automatic applyStimulus(input logic fe, input logic st, input logic rt,
                               input logic bt, input logic ba, input logic [15:0] tgt,
                               input logic iv, input logic [31:0] rd);
    fetch_en   = fe;
    stall      = st;
    retire     = rt;
    br_take    = bt;
    br_abs     = ba;
    br_target  = tgt;
    imem_valid = iv;
    imem_rdata = rd;
    step();
  endtask

  task automatic fetchOne(input logic [31:0] data, input int latency);
    applyStimulus(1, 0, 0, 0, 0, 16'h0, 0, 32'h0);
    for (int i = 1; i < latency; i++) applyStimulus(0, 0, 0, 0, 0, 16'h0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, data);
    imem_valid = 1'b0;
  endtask

  task automatic retireWith(input logic bt, input logic ba, input logic [15:0] tgt);
    applyStimulus(0, 0, 1, bt, ba, tgt, 0, 32'h0);
    retire  = 1'b0;
    br_take = 1'b0;
    br_abs  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state.
    step();
    cmp_en = 1'b1;
    step();
    checkOutput("rst_pc",       32'(pc),          32'h0);
    checkOutput("rst_ir",       ir,               32'h0);
    checkOutput("rst_ir_valid", 32'(ir_valid),    32'h0);
    checkOutput("rst_req",      32'(imem_req),    32'h0);
    checkOutput("rst_fault",    32'(fetch_fault), 32'h0);
    rst_f = 1'b1;
    step();

    // Single-cycle memory at address 0.
    applyStimulus(1, 0, 0, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("t1_req",  32'(imem_req),  32'h1);
    checkOutput("t1_addr", 32'(imem_addr), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 32'h12345678);
    checkOutput("t1_ir",       ir,            32'h12345678);
    checkOutput("t1_ir_valid", 32'(ir_valid), 32'h1);
    checkOutput("t1_pc",       32'(pc),       32'h1);
    checkOutput("t1_req_off",  32'(imem_req), 32'h0);
    // A response while holding is ignored.
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 32'hDEADBEEF);
    checkOutput("hold_ir_stable", ir, 32'h12345678);

    // Branch redirection.
    retireWith(1, 1, 16'h0004);
    checkOutput("abs_pc4", 32'(pc), 32'h4);
    fetchOne(32'hA5A50001, 1);
    checkOutput("pc5", 32'(pc), 32'h5);
    applyStimulus(0, 0, 0, 1, 1, 16'h1234, 0, 32'h0);
    checkOutput("br_no_retire_pc", 32'(pc), 32'h5);
    retireWith(1, 0, 16'hFFFE);
    checkOutput("rel_pc3",       32'(pc),       32'h3);
    checkOutput("rel_ir_valid",  32'(ir_valid), 32'h0);
    step();
    checkOutput("idle_no_req",   32'(imem_req), 32'h0);
    fetchOne(32'h0BADF00D, 1);
    retireWith(1, 1, 16'h0040);
    checkOutput("abs_pc40", 32'(pc), 32'h40);

    // Retire and fetch_en together: bubble, then issue.
    fetchOne(32'h11110000, 1);
    applyStimulus(1, 0, 1, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("bubble_req",      32'(imem_req), 32'h0);
    checkOutput("bubble_ir_valid", 32'(ir_valid), 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("bubble_issue",    32'(imem_req),  32'h1);
    checkOutput("bubble_addr",     32'(imem_addr), 32'h41);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 32'h22220000);
    checkOutput("bubble_ir", ir,      32'h22220000);
    checkOutput("bubble_pc", 32'(pc), 32'h42);
    retireWith(0, 0, 16'h0);

    // Stall blocks issue; same-cycle response ignored; slow memory with stall toggling.
    applyStimulus(1, 1, 0, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("stall_blocks", 32'(imem_req), 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0, 1, 32'hFFFFFFFF);
    checkOutput("slow_issue",   32'(imem_req), 32'h1);
    checkOutput("slow_no_early", 32'(ir_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, (i % 2 == 0), 0, 0, 0, 16'h0, 0, 32'h0);
      checkOutput("slow_req_held", 32'(imem_req),  32'h1);
      checkOutput("slow_addr",     32'(imem_addr), 32'h42);
    end
    applyStimulus(0, 1, 0, 0, 0, 16'h0, 1, 32'hCAFE0042);
    checkOutput("slow_ir",    ir,               32'hCAFE0042);
    checkOutput("slow_pc",    32'(pc),          32'h43);
    checkOutput("slow_fault", 32'(fetch_fault), 32'h0);
    stall = 1'b0;
    retireWith(0, 0, 16'h0);

    // PC wrap on increment and on relative branch.
    fetchOne(32'h33330043, 1);
    retireWith(1, 1, 16'hFFFF);
    checkOutput("pc_ffff", 32'(pc), 32'hFFFF);
    fetchOne(32'h7777FFFF, 2);
    checkOutput("wrap_pc", 32'(pc), 32'h0);
    retireWith(0, 0, 16'h0);
    checkOutput("wrap_pc_retire", 32'(pc), 32'h0);
    fetchOne(32'h44440000, 1);
    retireWith(1, 0, 16'h8000);
    checkOutput("rel_wrap_pc", 32'(pc), 32'h8001);

    // Reset in the middle of WAIT, then a late response.
    applyStimulus(1, 0, 0, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("mid_req", 32'(imem_req), 32'h1);
    fetch_en = 1'b0;
    rst_f    = 1'b0;
    #1;
    checkOutput("async_req", 32'(imem_req), 32'h0);
    checkOutput("async_pc",  32'(pc),       32'h0);
    step();
    rst_f = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 32'hBBBBBBBB);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 32'hBBBBBBBB);
    checkOutput("late_ir_valid", 32'(ir_valid), 32'h0);
    checkOutput("late_ir",       ir,            32'h0);
    imem_valid = 1'b0;

    // Memory never answers: timeout after TIMEOUT WAIT cycles.
    applyStimulus(1, 0, 0, 0, 0, 16'h0, 0, 32'h0);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 0, 0, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("to_req_still", 32'(imem_req),    32'h1);
    checkOutput("to_no_fault",  32'(fetch_fault), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 0, 32'h0);
    checkOutput("to_fault", 32'(fetch_fault), 32'h1);
    checkOutput("to_req",   32'(imem_req),    32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 1, 1, 16'h0010, 1, 32'h55555555);
    checkOutput("fault_sticky",   32'(fetch_fault), 32'h1);
    checkOutput("fault_ir_valid", 32'(ir_valid),    32'h0);
    checkOutput("fault_req",      32'(imem_req),    32'h0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0, 0, 32'h0);
    rst_f = 1'b0;
    step();
    rst_f = 1'b1;
    step();
    checkOutput("fault_cleared", 32'(fetch_fault), 32'h0);
    checkOutput("fault_rst_pc",  32'(pc),          32'(RESET_PC));

    step();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
